// File: rtl/fp_int_pkg.sv
// Shared FP16 field constants and the normaliser FSM state type.
package fp_int_pkg;

  localparam int unsigned BIAS    = 15;
  localparam int unsigned EXP_MAX = 31;
  localparam int unsigned MANT_W  = 10;
  localparam int unsigned EXP_W   = 5;
  localparam int unsigned FP16_W  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StNorm,
    StRound,
    StOut
  } norm_state_e;

endpackage

// File: rtl/fp16_round_pack.sv
// Combinational FP16 rounding and packing with overflow to infinity and flush-to-zero.
// FP_INT_NORM_RNE_EN selects round-to-nearest-even; otherwise the mantissa is truncated.
module fp16_round_pack
  import fp_int_pkg::*;
(
  input  logic              i_sign,
  input  logic signed [7:0] i_exp,
  input  logic [MANT_W-1:0] i_mant,
  input  logic              i_guard,
  input  logic              i_sticky,
  output logic [FP16_W-1:0] o_fp16
);

  logic              w_round_up;
  logic [MANT_W:0]   w_mant_sum;
  logic [MANT_W-1:0] w_mant_rnd;
  logic signed [8:0] w_exp_adj;

`ifdef FP_INT_NORM_RNE_EN
  assign w_round_up = i_guard & (i_sticky | i_mant[0]);
`else
  logic w_unused_rnd;
  assign w_unused_rnd = i_guard ^ i_sticky;
  assign w_round_up   = 1'b0;
`endif

  assign w_mant_sum = {1'b0, i_mant} + {{MANT_W{1'b0}}, w_round_up};
  // Carry out of the mantissa bumps the exponent; the fraction wraps to zero.
  assign w_mant_rnd = w_mant_sum[MANT_W] ? '0 : w_mant_sum[MANT_W-1:0];
  assign w_exp_adj  = $signed({i_exp[7], i_exp}) + $signed({8'd0, w_mant_sum[MANT_W]});

  always_comb begin
    o_fp16 = '0;
    if (w_exp_adj >= $signed(9'(EXP_MAX))) begin
      o_fp16 = {i_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (w_exp_adj <= 9'sd0) begin
      o_fp16 = {i_sign, {(FP16_W-1){1'b0}}};
    end else begin
      o_fp16 = {i_sign, w_exp_adj[EXP_W-1:0], w_mant_rnd};
    end
  end

endmodule

// File: rtl/fp_int_norm.sv
// Converts a signed fixed-point accumulator with shared exponent to FP16 by serial normalisation.
// Rounding mode is chosen by FP_INT_NORM_RNE_EN (see fp16_round_pack).
module fp_int_norm
  import fp_int_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned FRAC_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACC_WIDTH-1:0] fixed_point_in,
  input  logic [EXP_W-1:0]     exp_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FP16_W-1:0]    fp16_out
);

  localparam int unsigned CNT_W = $clog2(ACC_WIDTH) + 1;

  norm_state_e          r_state, w_state_d;
  logic                 r_sign, w_sign_d;
  logic [EXP_W-1:0]     r_exp, w_exp_d;
  logic [ACC_WIDTH-1:0] r_mag, w_mag_d;
  logic [CNT_W-1:0]     r_count, w_count_d;
  logic [FP16_W-1:0]    r_fp16, w_fp16_d;

  logic [ACC_WIDTH-1:0] w_abs_in;
  logic signed [7:0]    w_exp_e;
  logic [MANT_W-1:0]    w_mant;
  logic                 w_guard;
  logic                 w_sticky;
  logic [FP16_W-1:0]    w_packed;

  // Unsigned negation maps the most negative input onto 2^(ACC_WIDTH-1) exactly.
  assign w_abs_in = fixed_point_in[ACC_WIDTH-1] ? -fixed_point_in : fixed_point_in;

  assign w_exp_e  = 8'(r_exp) + 8'(ACC_WIDTH - 1) - 8'(r_count) - 8'(FRAC_BITS);
  assign w_mant   = r_mag[ACC_WIDTH-2 -: MANT_W];
  assign w_guard  = r_mag[ACC_WIDTH-2-MANT_W];
  assign w_sticky = |r_mag[ACC_WIDTH-3-MANT_W:0];

  fp16_round_pack u_round_pack (
    .i_sign   (r_sign),
    .i_exp    (w_exp_e),
    .i_mant   (w_mant),
    .i_guard  (w_guard),
    .i_sticky (w_sticky),
    .o_fp16   (w_packed)
  );

  always_comb begin
    w_state_d = r_state;
    w_sign_d  = r_sign;
    w_exp_d   = r_exp;
    w_mag_d   = r_mag;
    w_count_d = r_count;
    w_fp16_d  = r_fp16;
    case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_sign_d  = fixed_point_in[ACC_WIDTH-1];
          w_mag_d   = w_abs_in;
          w_exp_d   = exp_in;
          w_count_d = '0;
          w_state_d = StNorm;
        end
      end
      StNorm: begin
        if (r_mag[ACC_WIDTH-1] || (r_mag == '0)) begin
          w_state_d = StRound;
        end else begin
          w_mag_d   = r_mag << 1;
          w_count_d = r_count + CNT_W'(1);
        end
      end
      StRound: begin
        w_fp16_d  = (r_mag == '0) ? '0 : w_packed;
        w_state_d = StOut;
      end
      StOut: begin
        if (out_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_mag   <= '0;
      r_count <= '0;
      r_fp16  <= '0;
    end else begin
      r_state <= w_state_d;
      r_sign  <= w_sign_d;
      r_exp   <= w_exp_d;
      r_mag   <= w_mag_d;
      r_count <= w_count_d;
      r_fp16  <= w_fp16_d;
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StOut);
  assign fp16_out  = r_fp16;

endmodule

// File: tb/tb_fp_int_norm.sv
// Self-checking bench for fp_int_norm: directed vector table, handshake/reset sequences,
// and randomized operands against an arithmetic FP16 reference model.
module tb_fp_int_norm;

  localparam int unsigned ACC_WIDTH = 32;
  localparam int unsigned FRAC_BITS = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fixed_point_in;
  logic [4:0]  exp_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] fp16_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fp_int_norm #(
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .fixed_point_in (fixed_point_in),
    .exp_in         (exp_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .fp16_out       (fp16_out)
  );

  typedef struct {
    logic [31:0] fx;
    logic [4:0]  e;
    logic [15:0] fp;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Value = fx * 2^(e - 15 - FRAC_BITS); FP16 exponent field = e + p - FRAC_BITS for msb p.
  function automatic void ref_model(input logic [31:0] fx, input logic [4:0] e,
                                    output logic [15:0] fp, output int lat);
    longint v, m, frac, scaled, mant, rem, half, one;
    int     p, ex;
    logic   s;
    one = 1;
    v   = longint'($signed(fx));
    s   = (v < 0);
    m   = s ? -v : v;
    if (m == 0) begin
      fp  = 16'h0000;
      lat = 2;
      return;
    end
    p = 0;
    for (int i = 0; i < 40; i++) if (((m >> i) & one) == one) p = i;
    lat    = (31 - p) + 2;
    frac   = m - (one << p);
    scaled = frac * 1024;
    mant   = scaled >> p;
    rem    = scaled - (mant << p);
`ifdef FP_INT_NORM_RNE_EN
    if (p > 0) begin
      half = one << (p - 1);
      if ((rem > half) || ((rem == half) && ((mant & one) == one))) mant = mant + 1;
    end
`else
    half = rem;
`endif
    ex = int'(e) + p - int'(FRAC_BITS);
    if (mant == 1024) begin
      mant = 0;
      ex   = ex + 1;
    end
    if (ex >= 31) fp = {s, 5'h1F, 10'h000};
    else if (ex <= 0) fp = {s, 15'h0000};
    else fp = {s, 5'(ex), 10'(mant)};
  endfunction

  task automatic run_op(input logic [31:0] fx, input logic [4:0] e, input logic [15:0] req_fp,
                        input int req_lat, input string name);
    int lat;
    int wait_cnt;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 100) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    fixed_point_in = fx;
    exp_in         = e;
    in_valid       = 1'b1;
    @(posedge clk); #1;
    in_valid       = 1'b0;
    fixed_point_in = $urandom;
    exp_in         = 5'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 100);
    check({name, " latency"}, 32'(lat), 32'(req_lat));
    check({name, " fp16"}, 32'(fp16_out), 32'(req_fp));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " release"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] mfp;
    int          mlat;
    logic [31:0] rfx;
    logic [4:0]  re;
    int          hi_cnt;
    int          lat;

    vecs[0] = '{32'h0000_0400, 5'd15, 16'h3C00, 23};
    vecs[1] = '{32'hFFFF_F400, 5'd15, 16'hC200, 22};
`ifdef FP_INT_NORM_RNE_EN
    vecs[2] = '{32'h0000_0803, 5'd15, 16'h4002, 22};
    vecs[9] = '{32'h0000_0FFF, 5'd15, 16'h4400, 22};
`else
    vecs[2] = '{32'h0000_0803, 5'd15, 16'h4001, 22};
    vecs[9] = '{32'h0000_0FFF, 5'd15, 16'h43FF, 22};
`endif
    vecs[3] = '{32'h0000_0801, 5'd15, 16'h4000, 22};
    vecs[4] = '{32'h7FFF_FFFF, 5'd30, 16'h7C00, 3};
    vecs[5] = '{32'h0000_0001, 5'd5,  16'h0000, 33};
    vecs[6] = '{32'hFFFF_FFFF, 5'd5,  16'h8000, 33};
    vecs[7] = '{32'h0000_0000, 5'd15, 16'h0000, 2};
    vecs[8] = '{32'h8000_0000, 5'd15, 16'hFC00, 2};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; fixed_point_in = '0; exp_in = '0;
    #1 rst = 1'b0;
    #2;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset fp16", 32'(fp16_out), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("in_ready after release", 32'(in_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].fx, vecs[i].e, vecs[i].fp, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Backpressure: result held, new input ignored while waiting.
    fixed_point_in = 32'h0000_0400; exp_in = 5'd15; in_valid = 1'b1;
    @(posedge clk); #1;
    fixed_point_in = 32'h0000_0803;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 100);
    check("bp latency", 32'(lat), 32'd23);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp fp16 stable", 32'(fp16_out), 32'h3C00);
      check("bp in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp released", 32'(out_valid), 32'd0);
    check("bp idle", 32'(in_ready), 32'd1);

    // out_ready asserted early has no effect on when the result appears.
    out_ready = 1'b1;
    fixed_point_in = 32'hFFFF_F400; exp_in = 5'd15; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 100);
    check("early ready latency", 32'(lat), 32'd22);
    check("early ready fp16", 32'(fp16_out), 32'hC200);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("early ready idle", 32'(in_ready), 32'd1);

    // Reset in the middle of normalisation.
    fixed_point_in = 32'h0000_0001; exp_in = 5'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("mid-norm rst out_valid", 32'(out_valid), 32'd0);
    check("mid-norm rst fp16", 32'(fp16_out), 32'd0);
    check("mid-norm rst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    hi_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) hi_cnt++;
    end
    check("no result after rst", 32'(hi_cnt), 32'd0);

    for (int r = 0; r < 40; r++) begin
      rfx = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rfx = -rfx;
      re = 5'($urandom_range(0, 31));
      ref_model(rfx, re, mfp, mlat);
      run_op(rfx, re, mfp, mlat, $sformatf("rand%0d fx=%h e=%0d", r, rfx, re));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
